divider_arbiter: RTL and testbench

- Round-robin scheduler that shares one fully pipelined signed divider among NUM_REQ requesters.
- Accepts at most one operation per cycle and drives the divider's operand/valid inputs.
- Tracks each issued operation's requester ID through the fixed divider latency, then routes the quotient back tagged with that ID.
- Sits between the requesting engines and the divider instance.

---
 rtl/divider_arbiter.sv | 252 +++++++++++++++++++++++++
 tb/tb_divider_arbiter.sv | 373 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/divider_arbiter.sv
// divider_arbiter: round-robin front end that shares one fully pipelined signed divider
// among NUM_REQ requesters. Each issued operation carries its requester id down a tag
// pipeline that matches the divider latency, and the quotient returns tagged with that id.
// Optional build macro DIV_ZERO_BYPASS_EN: zero-divisor requests skip the divider and are
// answered locally with a saturated quotient and rsp_dz=1.
module divider_arbiter #(
  parameter int unsigned NUM_REQ         = 4,
  parameter int unsigned DIVIDEND_WIDTH  = 32,
  parameter int unsigned DIVISOR_WIDTH   = 24,
  parameter int unsigned DIV_LATENCY     = 34,
  parameter int unsigned MAX_OUTSTANDING = 8
) (
  input  logic                              sys_clk,
  input  logic                              sys_rst,
  input  logic [NUM_REQ-1:0]                req_valid,
  input  logic [NUM_REQ*DIVIDEND_WIDTH-1:0] req_dividend,
  input  logic [NUM_REQ*DIVISOR_WIDTH-1:0]  req_divisor,
  output logic [NUM_REQ-1:0]                req_ready,
  output logic [DIVIDEND_WIDTH-1:0]         div_dividend,
  output logic [DIVISOR_WIDTH-1:0]          div_divisor,
  output logic                              div_ivalid,
  input  logic [DIVIDEND_WIDTH-1:0]         div_quotient,
  input  logic                              div_ovalid,
  output logic                              rsp_valid,
  output logic [$clog2(NUM_REQ)-1:0]        rsp_id,
  output logic [DIVIDEND_WIDTH-1:0]         rsp_quotient,
`ifdef DIV_ZERO_BYPASS_EN
  output logic                              rsp_dz,
`endif
  output logic                              err_sync
);

  localparam int unsigned IdWidth  = $clog2(NUM_REQ);
  localparam int unsigned CntWidth = $clog2(MAX_OUTSTANDING + 1);
  localparam bit [IdWidth:0]    NumReqW = (IdWidth + 1)'(NUM_REQ);
  localparam bit [CntWidth-1:0] MaxCnt  = CntWidth'(MAX_OUTSTANDING);

  logic [NUM_REQ-1:0][CntWidth-1:0]     outstanding_q;
  logic [IdWidth-1:0]                   ptr_q;
  logic [IdWidth-1:0]                   issue_id_q;
  logic [DIV_LATENCY-1:0]               tag_valid_q;
  logic [DIV_LATENCY-1:0][IdWidth-1:0]  tag_id_q;

  logic [NUM_REQ-1:0]        eligible;
  logic [2*NUM_REQ-1:0]      elig_dbl;
  logic [NUM_REQ-1:0]        elig_rot;
  logic                      grant_any;
  logic [IdWidth-1:0]        grant_off;
  logic [IdWidth:0]          grant_sum;
  logic [IdWidth-1:0]        grant_id;
  logic [NUM_REQ-1:0]        grant;
  logic                      xfer;
  logic                      issue;
  logic [DIVIDEND_WIDTH-1:0] sel_dividend;
  logic [DIVISOR_WIDTH-1:0]  sel_divisor;
  logic [NUM_REQ-1:0]        cnt_inc;
  logic [NUM_REQ-1:0]        cnt_dec;
  logic                      tail_valid;
  logic [IdWidth-1:0]        tail_id;

  assign tail_valid = tag_valid_q[DIV_LATENCY-1];
  assign tail_id    = tag_id_q[DIV_LATENCY-1];

`ifdef DIV_ZERO_BYPASS_EN
  logic                      hold_valid_q;
  logic [IdWidth-1:0]        hold_id_q;
  logic [DIVIDEND_WIDTH-1:0] hold_quot_q;
  logic                      bypass_xfer;
  logic [DIVIDEND_WIDTH-1:0] sat_quot;

  assign bypass_xfer = xfer && (sel_divisor == '0);
  assign issue       = xfer && !bypass_xfer;
  // Saturate toward the sign of the dividend.
  assign sat_quot    = sel_dividend[DIVIDEND_WIDTH-1] ?
                       {1'b1, {(DIVIDEND_WIDTH-1){1'b0}}} : {1'b0, {(DIVIDEND_WIDTH-1){1'b1}}};
`else
  assign issue = xfer;
`endif

  // Requester eligibility: valid and below its in-flight credit limit.
  always_comb begin
    eligible = '0;
    for (int k = 0; k < int'(NUM_REQ); k++) begin
      eligible[k] = req_valid[k] && (outstanding_q[k] < MaxCnt);
`ifdef DIV_ZERO_BYPASS_EN
      // A full holding register cannot absorb another bypass result.
      if (hold_valid_q && (req_divisor[k*DIVISOR_WIDTH +: DIVISOR_WIDTH] == '0)) begin
        eligible[k] = 1'b0;
      end
`endif
    end
  end

  // Round-robin search: rotate eligibility so the pointer sits at bit 0, take lowest set bit.
  always_comb begin
    elig_dbl  = {eligible, eligible} >> ptr_q;
    elig_rot  = elig_dbl[NUM_REQ-1:0];
    grant_any = 1'b0;
    grant_off = '0;
    for (int i = int'(NUM_REQ) - 1; i >= 0; i--) begin
      if (elig_rot[i]) begin
        grant_any = 1'b1;
        grant_off = IdWidth'(i);
      end
    end
    grant_sum = {1'b0, ptr_q} + {1'b0, grant_off};
    grant_id  = (grant_sum >= NumReqW) ? IdWidth'(grant_sum - NumReqW) : grant_sum[IdWidth-1:0];
    grant     = '0;
    if (grant_any) begin
      grant[grant_id] = 1'b1;
    end
  end

  // No grants are offered while reset is held.
  assign req_ready = grant & {NUM_REQ{sys_rst}};
  assign xfer      = grant_any & sys_rst;

  // Operand mux for the granted requester.
  always_comb begin
    sel_dividend = '0;
    sel_divisor  = '0;
    for (int k = 0; k < int'(NUM_REQ); k++) begin
      if (grant[k]) begin
        sel_dividend = req_dividend[k*DIVIDEND_WIDTH +: DIVIDEND_WIDTH];
        sel_divisor  = req_divisor[k*DIVISOR_WIDTH +: DIVISOR_WIDTH];
      end
    end
  end

  // Issue register toward the divider; operands hold when idle.
  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      div_ivalid   <= 1'b0;
      div_dividend <= '0;
      div_divisor  <= '0;
      issue_id_q   <= '0;
    end else begin
      div_ivalid <= issue;
      if (issue) begin
        div_dividend <= sel_dividend;
        div_divisor  <= sel_divisor;
        issue_id_q   <= grant_id;
      end
    end
  end

  // Round-robin pointer moves just past the granted requester.
  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      ptr_q <= '0;
    end else if (xfer) begin
      ptr_q <= (grant_id == IdWidth'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;
    end
  end

  // Tag pipeline shadows the divider so the tail lines up with div_ovalid.
  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      tag_valid_q <= '0;
      tag_id_q    <= '0;
    end else begin
      tag_valid_q[0] <= div_ivalid;
      tag_id_q[0]    <= issue_id_q;
      for (int i = 1; i < int'(DIV_LATENCY); i++) begin
        tag_valid_q[i] <= tag_valid_q[i-1];
        tag_id_q[i]    <= tag_id_q[i-1];
      end
    end
  end

  // Response register; the tag pipeline, not div_ovalid, decides when a result is real.
  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      rsp_valid    <= 1'b0;
      rsp_id       <= '0;
      rsp_quotient <= '0;
`ifdef DIV_ZERO_BYPASS_EN
      rsp_dz       <= 1'b0;
      hold_valid_q <= 1'b0;
      hold_id_q    <= '0;
      hold_quot_q  <= '0;
`endif
    end else begin
      rsp_valid <= 1'b0;
`ifdef DIV_ZERO_BYPASS_EN
      rsp_dz    <= 1'b0;
`endif
      if (tail_valid) begin
        rsp_valid    <= 1'b1;
        rsp_id       <= tail_id;
        rsp_quotient <= div_quotient;
`ifdef DIV_ZERO_BYPASS_EN
        if (bypass_xfer) begin
          hold_valid_q <= 1'b1;
          hold_id_q    <= grant_id;
          hold_quot_q  <= sat_quot;
        end
      end else if (hold_valid_q) begin
        rsp_valid    <= 1'b1;
        rsp_id       <= hold_id_q;
        rsp_quotient <= hold_quot_q;
        rsp_dz       <= 1'b1;
        hold_valid_q <= 1'b0;
      end else if (bypass_xfer) begin
        rsp_valid    <= 1'b1;
        rsp_id       <= grant_id;
        rsp_quotient <= sat_quot;
        rsp_dz       <= 1'b1;
`endif
      end
    end
  end

  // Credit bookkeeping: increment on divider issue, decrement on a divider-sourced response.
  always_comb begin
    cnt_inc = '0;
    cnt_dec = '0;
    for (int k = 0; k < int'(NUM_REQ); k++) begin
      cnt_inc[k] = issue && grant[k];
`ifdef DIV_ZERO_BYPASS_EN
      cnt_dec[k] = rsp_valid && !rsp_dz && (rsp_id == IdWidth'(k));
`else
      cnt_dec[k] = rsp_valid && (rsp_id == IdWidth'(k));
`endif
    end
  end

  // Per-requester outstanding counters, saturating at both ends.
  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      outstanding_q <= '0;
    end else begin
      for (int k = 0; k < int'(NUM_REQ); k++) begin
        if (cnt_inc[k] && !cnt_dec[k] && (outstanding_q[k] != MaxCnt)) begin
          outstanding_q[k] <= outstanding_q[k] + 1'b1;
        end else if (cnt_dec[k] && !cnt_inc[k] && (outstanding_q[k] != '0)) begin
          outstanding_q[k] <= outstanding_q[k] - 1'b1;
        end
      end
    end
  end

  // Sticky flag for any disagreement between the divider strobe and the tag tail.
  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      err_sync <= 1'b0;
    end else if (div_ovalid != tail_valid) begin
      err_sync <= 1'b1;
    end
  end

endmodule

// File: tb/tb_divider_arbiter.sv
// Bench for divider_arbiter: a behavioural divider with fixed latency, a queue-based
// reference model checked every cycle, plus directed scenarios with literal expectations.
`timescale 1ns/1ps
module tb_divider_arbiter;

  localparam int N    = 4;
  localparam int DW   = 32;
  localparam int SW   = 24;
  localparam int LAT  = 34;
  localparam int MAXO = 2;
  localparam int IW   = 2;

  logic            sys_clk = 1'b0;
  logic            sys_rst = 1'b0;
  logic [N-1:0]    req_valid;
  logic [N*DW-1:0] req_dividend;
  logic [N*SW-1:0] req_divisor;
  logic [N-1:0]    req_ready;
  logic [DW-1:0]   div_dividend;
  logic [SW-1:0]   div_divisor;
  logic            div_ivalid;
  logic [DW-1:0]   div_quotient;
  logic            div_ovalid;
  logic            rsp_valid;
  logic [IW-1:0]   rsp_id;
  logic [DW-1:0]   rsp_quotient;
  logic            err_sync;
`ifdef DIV_ZERO_BYPASS_EN
  logic            rsp_dz;
`endif

  logic [DW-1:0] dvd [N];
  logic [SW-1:0] dvs [N];
  logic          inj;

  int n_pass  = 0;
  int n_total = 0;

  always #5 sys_clk = ~sys_clk;

  divider_arbiter #(
    .NUM_REQ         (N),
    .DIVIDEND_WIDTH  (DW),
    .DIVISOR_WIDTH   (SW),
    .DIV_LATENCY     (LAT),
    .MAX_OUTSTANDING (MAXO)
  ) dut (
    .sys_clk      (sys_clk),
    .sys_rst      (sys_rst),
    .req_valid    (req_valid),
    .req_dividend (req_dividend),
    .req_divisor  (req_divisor),
    .req_ready    (req_ready),
    .div_dividend (div_dividend),
    .div_divisor  (div_divisor),
    .div_ivalid   (div_ivalid),
    .div_quotient (div_quotient),
    .div_ovalid   (div_ovalid),
    .rsp_valid    (rsp_valid),
    .rsp_id       (rsp_id),
    .rsp_quotient (rsp_quotient),
`ifdef DIV_ZERO_BYPASS_EN
    .rsp_dz       (rsp_dz),
`endif
    .err_sync     (err_sync)
  );

  always_comb begin
    req_dividend = '0;
    req_divisor  = '0;
    for (int k = 0; k < N; k++) begin
      req_dividend[k*DW +: DW] = dvd[k];
      req_divisor[k*SW +: SW]  = dvs[k];
    end
  end

  // Signed division truncating toward zero.
  function automatic logic [DW-1:0] sdiv(input logic [DW-1:0] a, input logic [SW-1:0] b);
    logic signed [DW-1:0] sa;
    logic signed [DW-1:0] sb;
    sa = a;
    sb = {{(DW-SW){b[SW-1]}}, b};
    if (sb == 0) return '0;
    if (sb == -1) return -sa;
    return sa / sb;
  endfunction

  // Behavioural divider: fixed latency, reset by the same sys_rst.
  logic [LAT-1:0] bd_v;
  logic [DW-1:0]  bd_q [LAT];
  always @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      bd_v <= '0;
      for (int i = 0; i < LAT; i++) bd_q[i] <= '0;
    end else begin
      bd_v[0] <= div_ivalid;
      bd_q[0] <= sdiv(div_dividend, div_divisor);
      for (int i = 1; i < LAT; i++) begin
        bd_v[i] <= bd_v[i-1];
        bd_q[i] <= bd_q[i-1];
      end
    end
  end
  assign div_ovalid   = bd_v[LAT-1] | inj;
  assign div_quotient = bd_q[LAT-1];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  // Reference model: in-flight operations as a queue of {due cycle, id, quotient}.
  typedef struct {
    int            due;
    int            id;
    logic [DW-1:0] quot;
  } ent_t;

  ent_t          mq[$];
  int            m_ptr = 0;
  bit            m_prev_xfer = 1'b0;
  logic [DW-1:0] m_prev_dvd;
  logic [SW-1:0] m_prev_dvs;
  bit            m_err = 1'b0;
  int            cyc = 0;

  always @(negedge sys_clk) begin : cmp
    int           cnt [N];
    int           gk;
    int           idx;
    logic [N-1:0] exp_ready;
    bit           exp_rsp;
    cyc++;
    if (!sys_rst) begin
      chk("rst_ready", 64'(req_ready), 64'(0));
      chk("rst_ivalid", 64'(div_ivalid), 64'(0));
      chk("rst_rsp_valid", 64'(rsp_valid), 64'(0));
      chk("rst_err", 64'(err_sync), 64'(0));
      mq.delete();
      m_ptr       = 0;
      m_prev_xfer = 1'b0;
      m_err       = 1'b0;
    end else begin
      for (int k = 0; k < N; k++) cnt[k] = 0;
      foreach (mq[i]) cnt[mq[i].id]++;
      gk = -1;
      for (int s = 0; s < N; s++) begin
        idx = (m_ptr + s) % N;
        if (gk < 0 && req_valid[idx] && cnt[idx] < MAXO) gk = idx;
      end
      exp_ready = '0;
      if (gk >= 0) exp_ready[gk] = 1'b1;
      exp_rsp = (mq.size() > 0) && (mq[0].due == cyc);

      chk("req_ready", 64'(req_ready), 64'(exp_ready));
      chk("div_ivalid", 64'(div_ivalid), 64'(m_prev_xfer));
      if (m_prev_xfer) begin
        chk("div_operands", {8'h0, div_divisor, div_dividend}, {8'h0, m_prev_dvs, m_prev_dvd});
      end
      chk("rsp_valid", 64'(rsp_valid), 64'(exp_rsp));
      if (exp_rsp) begin
        chk("rsp_id", 64'(rsp_id), 64'(mq[0].id));
        chk("rsp_quotient", 64'(rsp_quotient), 64'(mq[0].quot));
        void'(mq.pop_front());
      end
      chk("err_sync", 64'(err_sync), 64'(m_err));

      if (gk >= 0) begin
        mq.push_back('{due: cyc + LAT + 2, id: gk, quot: sdiv(dvd[gk], dvs[gk])});
        m_ptr       = (gk + 1) % N;
        m_prev_xfer = 1'b1;
        m_prev_dvd  = dvd[gk];
        m_prev_dvs  = dvs[gk];
      end else begin
        m_prev_xfer = 1'b0;
      end
      if (inj) m_err = 1'b1;
    end
  end

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic neg();
    @(negedge sys_clk);
  endtask

  // Called just after a rising edge; returns shortly after a rising edge with reset released.
  task automatic do_reset();
    req_valid = '0;
    sys_rst   = 1'b0;
    repeat (2) @(posedge sys_clk);
    #3 sys_rst = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1);
  end

  initial begin
    int            ng;
    int            rc;
    logic [N-1:0]  g [8];
    logic [DW-1:0] sexp [3];

    req_valid = '0;
    inj       = 1'b0;
    for (int k = 0; k < N; k++) begin
      dvd[k] = '0;
      dvs[k] = 24'd1;
    end

    // Reset values.
    neg();
    chk("reset_ready", 64'(req_ready), 64'(0));
    chk("reset_div_dividend", 64'(div_dividend), 64'(0));
    chk("reset_div_divisor", 64'(div_divisor), 64'(0));
    chk("reset_rsp_quotient", 64'(rsp_quotient), 64'(0));
    chk("reset_rsp_id", 64'(rsp_id), 64'(0));
    @(posedge sys_clk);
    #3 sys_rst = 1'b1;

    // Single op: requester 2, 100/7.
    tick();
    dvd[2] = 32'd100;
    dvs[2] = 24'd7;
    req_valid = 4'b0100;
    neg();
    chk("single_ready", 64'(req_ready), 64'(4'b0100));
    tick();
    req_valid = '0;
    repeat (34) neg();
    neg();
    chk("single_not_early", 64'(rsp_valid), 64'(0));
    neg();
    chk("single_rsp", {rsp_valid, 29'h0, rsp_id, rsp_quotient},
        {1'b1, 29'h0, 2'd2, 32'd14});

    // Fairness: all requesters valid for 8 cycles.
    tick();
    do_reset();
    for (int k = 0; k < N; k++) begin
      dvd[k] = 32'(1000 * (k + 1) + k);
      dvs[k] = 24'(k + 3);
    end
    tick();
    req_valid = 4'hF;
    for (int i = 0; i < 8; i++) begin
      neg();
      g[i] = req_ready;
      tick();
    end
    req_valid = '0;
    for (int i = 0; i < 8; i++) chk("fair_grant", 64'(g[i]), 64'(4'b0001 << (i % 4)));
    repeat (28) neg();
    for (int i = 0; i < 8; i++) begin
      neg();
      chk("fair_rsp_order", 64'({rsp_valid, rsp_id}), 64'({1'b1, IW'(i % 4)}));
    end

    // Signs.
    tick();
    do_reset();
    dvd[0] = -32'sd100; dvs[0] = 24'sd7;
    dvd[1] = 32'sd100;  dvs[1] = -24'sd7;
    dvd[2] = -32'sd100; dvs[2] = -24'sd7;
    sexp[0] = -32'sd14;
    sexp[1] = -32'sd14;
    sexp[2] = 32'sd14;
    tick();
    req_valid = 4'b0111;
    repeat (3) tick();
    req_valid = '0;
    repeat (33) neg();
    for (int i = 0; i < 3; i++) begin
      neg();
      chk("sign_quot", {31'h0, rsp_valid, rsp_quotient}, {31'h0, 1'b1, sexp[i]});
    end

    // Credit limit: requester 0 alone.
    tick();
    do_reset();
    dvd[0] = 32'd50;
    dvs[0] = 24'd5;
    tick();
    req_valid = 4'b0001;
    ng = 0;
    for (int c = 0; c < 37; c++) begin
      neg();
      if (req_ready[0]) ng++;
      tick();
    end
    neg();
    chk("credit_grants", 64'(ng), 64'(2));
    chk("credit_regrant", 64'(req_ready), 64'(4'b0001));
    tick();
    req_valid = '0;

    // Reset at cycle 10 of a 6-op burst.
    tick();
    do_reset();
    for (int k = 0; k < N; k++) begin
      dvd[k] = 32'($urandom);
      dvs[k] = 24'($urandom_range(1, 500));
    end
    tick();
    req_valid = 4'hF;
    repeat (6) tick();
    req_valid = '0;
    repeat (4) tick();
    do_reset();
    rc = 0;
    for (int c = 0; c < 50; c++) begin
      neg();
      if (rsp_valid) rc++;
      tick();
    end
    chk("reset_no_rsp", 64'(rc), 64'(0));
    chk("reset_err_clear", 64'(err_sync), 64'(0));
    req_valid = 4'b0001;
    neg();
    chk("reset_credit0", 64'(req_ready), 64'(4'b0001));
    tick();
    neg();
    chk("reset_credit1", 64'(req_ready), 64'(4'b0001));
    tick();
    req_valid = '0;

    // Sync error with an empty tag pipeline.
    repeat (LAT + 6) tick();
    inj = 1'b1;
    neg();
    chk("sync_before", 64'(err_sync), 64'(0));
    tick();
    inj = 1'b0;
    neg();
    chk("sync_set", 64'(err_sync), 64'(1));
    repeat (5) tick();
    neg();
    chk("sync_sticky", 64'(err_sync), 64'(1));
    tick();
    do_reset();
    neg();
    chk("sync_reset", 64'(err_sync), 64'(0));

    // Randomized traffic with varying load.
    tick();
    for (int c = 0; c < 3000; c++) begin
      for (int k = 0; k < N; k++) begin
        req_valid[k] = ($urandom_range(0, 99) < ((c / 500) % 2 == 0 ? 70 : 25));
        dvd[k] = 32'($urandom);
        case ($urandom_range(0, 2))
          0: dvs[k] = 24'($urandom_range(1, 20));
          1: dvs[k] = -24'($urandom_range(1, 20));
          default: dvs[k] = 24'($urandom);
        endcase
        if (dvs[k] == '0) dvs[k] = 24'd3;
      end
      tick();
    end
    req_valid = '0;
    repeat (LAT + 6) tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
